// File: rtl/cdb_writeback_arbiter_pkg.sv
// Shared constants, CDB entry type and tag field helpers for the writeback path.
// Tag layout: RS id in the upper bits, RS row index in the lower bits.
package cdb_writeback_arbiter_pkg;

  localparam int DEF_BITWIDTH   = 32;
  localparam int DEF_NRALUOP    = 8;
  localparam int DEF_RS_DEPTH   = 8;
  localparam int DEF_FIFO_DEPTH = 2;
  localparam int CDB_ROW_W      = $clog2(DEF_RS_DEPTH);
  localparam int CDB_TAG_W      = $clog2(DEF_NRALUOP) + CDB_ROW_W;

  typedef struct packed {
    logic [CDB_TAG_W-1:0]    tag;
    logic [DEF_BITWIDTH-1:0] data;
  } cdb_entry_t;

  function automatic logic [CDB_TAG_W-CDB_ROW_W-1:0] tag_rs_id(input logic [CDB_TAG_W-1:0] tag);
    return tag[CDB_TAG_W-1:CDB_ROW_W];
  endfunction

  function automatic logic [CDB_ROW_W-1:0] tag_row(input logic [CDB_TAG_W-1:0] tag);
    return tag[CDB_ROW_W-1:0];
  endfunction

endpackage

// File: rtl/cdb_writeback_arbiter_if.sv
// Result-port and CDB broadcast bundle between the processing elements and the arbiter.
// master = result producers / CDB snoopers, slave = the arbiter.
interface cdb_writeback_arbiter_if
  import cdb_writeback_arbiter_pkg::*;
#(
  parameter int NRALUOP  = DEF_NRALUOP,
  parameter int TAG_W    = CDB_TAG_W,
  parameter int BITWIDTH = DEF_BITWIDTH
);

  logic [NRALUOP-1:0]                res_valid;
  logic [NRALUOP-1:0][TAG_W-1:0]     res_tag;
  logic [NRALUOP-1:0][BITWIDTH-1:0]  res_data;
  logic [NRALUOP-1:0]                res_ready;
  logic                              cdb_valid;
  logic [TAG_W-1:0]                  cdb_tag;
  logic [BITWIDTH-1:0]               cdb_data;
  logic [$clog2(NRALUOP)-1:0]        cdb_src;

  modport master (
    output res_valid, res_tag, res_data,
    input  res_ready, cdb_valid, cdb_tag, cdb_data, cdb_src
  );

  modport slave (
    input  res_valid, res_tag, res_data,
    output res_ready, cdb_valid, cdb_tag, cdb_data, cdb_src
  );

endinterface

// File: rtl/cdb_writeback_arbiter_fifo.sv
// Per-unit result buffer; full/empty derive from wrap-bit pointers, no bypass.
// Caller gates push/pop; a full buffer ignores push even when popped the same cycle.
module cdb_fifo #(
  parameter type T     = logic,
  parameter int  DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic push,
  input  logic pop,
  input  T     din,
  output T     dout,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  T            r_mem [DEPTH];
  logic        w_do_push;
  logic        w_do_pop;

  assign empty     = (r_wr_ptr == r_rd_ptr);
  assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign dout      = r_mem[r_rd_ptr[AW-1:0]];
  assign w_do_push = push && !full && !flush;
  assign w_do_pop  = pop && !empty && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/cdb_writeback_arbiter.sv
// Buffers per-unit results and broadcasts one {tag,data} per cycle on the CDB, round-robin.
// Registered CDB output; res_ready depends only on registered occupancy and en.
module cdb_writeback_arbiter
  import cdb_writeback_arbiter_pkg::*;
#(
  parameter int BITWIDTH   = DEF_BITWIDTH,
  parameter int NRALUOP    = DEF_NRALUOP,
  parameter int RS_DEPTH   = DEF_RS_DEPTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_flush,
  cdb_writeback_arbiter_if.slave bus
);

  localparam int TAG_W = $clog2(NRALUOP) + $clog2(RS_DEPTH);
  localparam int SRC_W = $clog2(NRALUOP);

  typedef struct packed {
    logic [TAG_W-1:0]    tag;
    logic [BITWIDTH-1:0] data;
  } entry_t;

  entry_t              w_head [NRALUOP];
  logic [NRALUOP-1:0]  w_full;
  logic [NRALUOP-1:0]  w_empty;
  logic [NRALUOP-1:0]  w_ready;
  logic [NRALUOP-1:0]  w_push;
  logic [NRALUOP-1:0]  w_pop;
  logic                w_win_vld;
  logic [SRC_W-1:0]    w_win;

  logic [SRC_W-1:0]    r_rr_ptr;
  logic                r_cdb_valid;
  logic [TAG_W-1:0]    r_cdb_tag;
  logic [BITWIDTH-1:0] r_cdb_data;
  logic [SRC_W-1:0]    r_cdb_src;

  assign w_ready       = {NRALUOP{i_en}} & ~w_full;
  assign w_push        = bus.res_valid & w_ready & {NRALUOP{~i_flush}};
  assign bus.res_ready = w_ready;

  for (genvar gi = 0; gi < NRALUOP; gi++) begin : g_buf
    cdb_fifo #(
      .T     (entry_t),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (i_flush),
      .push  (w_push[gi]),
      .pop   (w_pop[gi]),
      .din   ({bus.res_tag[gi], bus.res_data[gi]}),
      .dout  (w_head[gi]),
      .full  (w_full[gi]),
      .empty (w_empty[gi])
    );
  end

  // Walk downward so the lowest offset from rr_ptr is the final (winning) assignment.
  always_comb begin
    int idx;
    w_win_vld = 1'b0;
    w_win     = '0;
    for (int k = NRALUOP - 1; k >= 0; k--) begin
      idx = int'(r_rr_ptr) + k;
      if (idx >= NRALUOP) idx = idx - NRALUOP;
      if (!w_empty[idx]) begin
        w_win_vld = 1'b1;
        w_win     = SRC_W'(idx);
      end
    end
  end

  assign w_pop = (w_win_vld && i_en && !i_flush)
               ? ({{(NRALUOP-1){1'b0}}, 1'b1} << w_win)
               : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr    <= '0;
      r_cdb_valid <= 1'b0;
      r_cdb_tag   <= '0;
      r_cdb_data  <= '0;
      r_cdb_src   <= '0;
    end else if (i_flush) begin
      r_rr_ptr    <= '0;
      r_cdb_valid <= 1'b0;
    end else if (!i_en) begin
      r_cdb_valid <= 1'b0;
    end else if (w_win_vld) begin
      r_cdb_valid <= 1'b1;
      r_cdb_tag   <= w_head[w_win].tag;
      r_cdb_data  <= w_head[w_win].data;
      r_cdb_src   <= w_win;
      r_rr_ptr    <= (w_win == SRC_W'(NRALUOP - 1)) ? '0 : w_win + SRC_W'(1);
    end else begin
      r_cdb_valid <= 1'b0;
    end
  end

  assign bus.cdb_valid = r_cdb_valid;
  assign bus.cdb_tag   = r_cdb_tag;
  assign bus.cdb_data  = r_cdb_data;
  assign bus.cdb_src   = r_cdb_src;

endmodule

// File: tb/tb_cdb_writeback_arbiter.sv
// Directed bench for cdb_writeback_arbiter with a tag/data scoreboard on every broadcast.
module tb_cdb_writeback_arbiter;
  import cdb_writeback_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic en;
  logic flush;

  int checks   = 0;
  int failures = 0;

  cdb_writeback_arbiter_if bus ();

  cdb_writeback_arbiter dut (
    .clk     (clk),
    .rst     (rst),
    .i_en    (en),
    .i_flush (flush),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  logic [CDB_TAG_W-1:0] pending [int];
  logic [7:0] auto_mask;
  logic [7:0] saw_low;
  int         seq     [8];
  int         low_run [8];
  int         max_low [8];
  int         n_bcast;
  int         snap;
  int         src_log [$];

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
    end
  endtask

  task automatic offer(input int i, input logic [5:0] tag, input logic [31:0] data);
    bus.res_valid[i] = 1'b1;
    bus.res_tag[i]   = tag;
    bus.res_data[i]  = data;
  endtask

  task automatic load_auto(input int i);
    bus.res_valid[i] = 1'b1;
    bus.res_tag[i]   = 6'((i << 3) | (seq[i] & 7));
    bus.res_data[i]  = 32'h8000_0000 | 32'(i << 16) | 32'(seq[i]);
  endtask

  task automatic tick();
    logic [7:0]  acc;
    logic [5:0]  t_cap [8];
    logic [31:0] d_cap [8];
    int key;
    acc = bus.res_valid & bus.res_ready & {8{en & ~flush & ~rst}};
    for (int i = 0; i < 8; i++) begin
      t_cap[i] = bus.res_tag[i];
      d_cap[i] = bus.res_data[i];
      if (bus.res_valid[i] && en && !flush) begin
        if (!bus.res_ready[i]) begin
          low_run[i]++;
          saw_low[i] = 1'b1;
          if (low_run[i] > max_low[i]) max_low[i] = low_run[i];
        end else begin
          low_run[i] = 0;
        end
      end
    end
    @(posedge clk);
    #1;
    if (flush || rst) pending.delete();
    for (int i = 0; i < 8; i++)
      if (acc[i]) pending[int'(d_cap[i])] = t_cap[i];
    if (bus.cdb_valid) begin
      n_bcast++;
      src_log.push_back(int'(bus.cdb_src));
      key = int'(bus.cdb_data);
      check("sb_known", 64'(pending.exists(key)), 64'(1));
      if (pending.exists(key)) begin
        check("sb_tag", 64'(bus.cdb_tag), 64'(pending[key]));
        pending.delete(key);
      end
    end
    for (int i = 0; i < 8; i++)
      if (acc[i] && auto_mask[i]) begin
        seq[i]++;
        load_auto(i);
      end
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; flush = 1'b0;
    bus.res_valid = '0; bus.res_tag = '0; bus.res_data = '0;
    auto_mask = '0; saw_low = '0; n_bcast = 0;
    for (int i = 0; i < 8; i++) begin seq[i] = 0; low_run[i] = 0; max_low[i] = 0; end

    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 64'(bus.cdb_valid), 64'(0));
    check("rst_tag",   64'(bus.cdb_tag),   64'(0));
    check("rst_data",  64'(bus.cdb_data),  64'(0));
    check("rst_src",   64'(bus.cdb_src),   64'(0));
    rst = 1'b0;
    #1;
    check("rst_ready", 64'(bus.res_ready), 64'(8'hFF));

    // Contention from rr_ptr=0: units 0, 5, 7 drain back to back.
    offer(0, 6'h02, 32'h1000_0000);
    offer(5, 6'h2A, 32'h1000_0005);
    offer(7, 6'h3B, 32'h1000_0007);
    tick(); bus.res_valid = '0;
    check("cont_nobypass", 64'(bus.cdb_valid), 64'(0));
    tick();
    check("cont_v0",   64'(bus.cdb_valid), 64'(1));
    check("cont_src0", 64'(bus.cdb_src),   64'(0));
    check("cont_tag0", 64'(bus.cdb_tag),   64'(6'h02));
    tick();
    check("cont_v1",   64'(bus.cdb_valid), 64'(1));
    check("cont_src1", 64'(bus.cdb_src),   64'(5));
    check("cont_tag1", 64'(bus.cdb_tag),   64'(6'h2A));
    tick();
    check("cont_v2",   64'(bus.cdb_valid), 64'(1));
    check("cont_src2", 64'(bus.cdb_src),   64'(7));
    check("cont_dat2", 64'(bus.cdb_data),  64'(32'h1000_0007));
    tick();
    check("cont_idle", 64'(bus.cdb_valid), 64'(0));

    // Single result from unit 3.
    offer(3, 6'h1B, 32'hDEADBEEF);
    tick(); bus.res_valid = '0;
    check("single_nobypass", 64'(bus.cdb_valid), 64'(0));
    tick();
    check("single_valid", 64'(bus.cdb_valid), 64'(1));
    check("single_tag",   64'(bus.cdb_tag),   64'(6'h1B));
    check("single_data",  64'(bus.cdb_data),  64'(32'hDEADBEEF));
    check("single_src",   64'(bus.cdb_src),   64'(3));
    tick();
    check("single_pulse",    64'(bus.cdb_valid), 64'(0));
    check("single_hold_tag", 64'(bus.cdb_tag),   64'(6'h1B));
    check("single_hold_src", 64'(bus.cdb_src),   64'(3));

    // Enable low freezes the buffered result and blocks acceptance.
    offer(5, 6'h2C, 32'h5555_0005);
    tick(); bus.res_valid = '0;
    en = 1'b0;
    #1;
    check("en0_ready", 64'(bus.res_ready), 64'(0));
    tick();
    check("en0_valid_a", 64'(bus.cdb_valid), 64'(0));
    tick();
    check("en0_valid_b", 64'(bus.cdb_valid), 64'(0));
    en = 1'b1;
    tick();
    check("en1_valid", 64'(bus.cdb_valid), 64'(1));
    check("en1_src",   64'(bus.cdb_src),   64'(5));
    check("en1_data",  64'(bus.cdb_data),  64'(32'h5555_0005));
    tick();

    // Fairness: units 1 and 2 offer continuously.
    src_log.delete();
    for (int i = 0; i < 8; i++) begin low_run[i] = 0; max_low[i] = 0; end
    auto_mask = 8'b0000_0110;
    load_auto(1); load_auto(2);
    repeat (9) tick();
    auto_mask = '0; bus.res_valid = '0;
    repeat (4) tick();
    check("fair_s0", 64'(src_log[0]), 64'(1));
    check("fair_s1", 64'(src_log[1]), 64'(2));
    check("fair_s2", 64'(src_log[2]), 64'(1));
    check("fair_s3", 64'(src_log[3]), 64'(2));
    check("fair_low1", 64'(max_low[1] <= 2), 64'(1));
    check("fair_low2", 64'(max_low[2] <= 2), 64'(1));
    check("fair_drained", 64'(pending.size()), 64'(0));

    // All units offer every cycle: buffers fill and back-pressure.
    saw_low = '0;
    for (int i = 0; i < 8; i++) begin seq[i] = 0; load_auto(i); end
    auto_mask = 8'hFF;
    #1;
    check("bp_ready0", 64'(bus.res_ready), 64'(8'hFF));
    repeat (24) tick();
    auto_mask = '0; bus.res_valid = '0;
    repeat (20) tick();
    check("bp_saw_low", 64'(saw_low), 64'(8'hFF));
    check("bp_drained", 64'(pending.size()), 64'(0));

    // Flush with three results buffered and a same-cycle push from unit 4.
    offer(0, 6'h01, 32'h7000_0000);
    offer(1, 6'h09, 32'h7000_0001);
    offer(2, 6'h11, 32'h7000_0002);
    offer(3, 6'h19, 32'h7000_0003);
    tick(); bus.res_valid = '0;
    tick();
    check("flush_pre_valid", 64'(bus.cdb_valid), 64'(1));
    flush = 1'b1;
    offer(4, 6'h21, 32'h4444_4444);
    tick();
    flush = 1'b0; bus.res_valid = '0;
    #1;
    check("flush_valid", 64'(bus.cdb_valid), 64'(0));
    check("flush_ready", 64'(bus.res_ready), 64'(8'hFF));
    snap = n_bcast;
    repeat (5) tick();
    check("flush_silent", 64'(n_bcast - snap), 64'(0));

    // Asynchronous reset mid-broadcast.
    offer(3, 6'h1A, 32'h3333_0003);
    tick(); bus.res_valid = '0;
    tick();
    check("arst_pre_valid", 64'(bus.cdb_valid), 64'(1));
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", 64'(bus.cdb_valid), 64'(0));
    check("arst_tag",   64'(bus.cdb_tag),   64'(0));
    check("arst_data",  64'(bus.cdb_data),  64'(0));
    check("arst_src",   64'(bus.cdb_src),   64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    pending.delete();
    offer(2, 6'h12, 32'h2222_0002);
    offer(6, 6'h32, 32'h6666_0006);
    tick(); bus.res_valid = '0;
    tick();
    check("arst_first_src", 64'(bus.cdb_src), 64'(2));
    tick();
    check("arst_second_src", 64'(bus.cdb_src), 64'(6));
    tick();
    check("arst_idle", 64'(bus.cdb_valid), 64'(0));
    check("arst_drained", 64'(pending.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cdb_writeback_arbiter.md
Name: cdb_writeback_arbiter

Overview:
- Completion-side counterpart of the reservation-station dispatch path.
- Accepts finished results from the NRALUOP processing elements, buffers them per unit, and arbitrates round-robin.
- Broadcasts one {tag, data} per cycle on the common data bus (CDB). Reservation stations and the RAT snoop the CDB to wake operands and retire aliases.
- Each result tag identifies its producer: the RS id in the upper bits, the RS row index in the lower bits.

Parameters:
- BITWIDTH, 32, result data width.
- NRALUOP, 8, number of processing elements / result ports.
- RS_DEPTH, 8, rows per reservation station (sets tag width).
- FIFO_DEPTH, 2, result buffer entries per processing element (power of 2, >=2).
- TAG_W, $clog2(NRALUOP)+$clog2(RS_DEPTH), derived localparam; not overridable.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  global enable. Low freezes all state, forces res_ready=0, and no pop occurs.
- flush  in  1  synchronous squash of all buffered results.
- res_valid  in  [NRALUOP]  result offered by unit i.
- res_tag  in  [NRALUOP][TAG_W]  producer tag of unit i's result.
- res_data  in  [NRALUOP][BITWIDTH]  result value of unit i.
- res_ready  out  [NRALUOP]  unit i's buffer can accept this cycle.
- cdb_valid  out  1  broadcast valid (registered).
- cdb_tag  out  TAG_W  broadcast tag (registered).
- cdb_data  out  BITWIDTH  broadcast value (registered).
- cdb_src  out  $clog2(NRALUOP)  index of the granted unit (registered).

Behaviour:
- Reset (async, any time including mid-broadcast):
  - All buffers empty; rr_ptr=0.
  - cdb_valid=0; cdb_tag, cdb_data and cdb_src = 0.
  - res_ready = all ones after rst deasserts (while en=1).
- res_ready[i]:
  - Equals en && !full_i, computed from registered occupancy only.
  - It does not depend on a same-cycle pop, so there is no combinational path from the arbiter to res_ready.
- Push: at the edge where res_valid[i] && res_ready[i] && !flush, {res_tag[i], res_data[i]} is written to buffer i. res_valid with res_ready=0 is ignored; the unit must hold its result.
- Arbitration (combinational, on registered buffer heads):
  - Scan units rr_ptr, rr_ptr+1, ... modulo NRALUOP; the first non-empty buffer wins.
- At each edge with en=1 and !flush:
  - If a winner w exists: pop buffer w; load cdb_valid=1, cdb_tag, cdb_data, cdb_src=w; rr_ptr <= (w+1) mod NRALUOP.
  - If no winner: cdb_valid <= 0; rr_ptr unchanged. cdb_tag, cdb_data and cdb_src hold their values.
- Latency: a result accepted at edge E is popped at edge E+1 at the earliest and is visible on the CDB during the cycle following E+1. There is no bypass.
- cdb_valid is a one-cycle pulse per result. Each accepted result is broadcast exactly once.
- Simultaneous push and pop on the same buffer is legal and leaves occupancy unchanged. A full buffer never accepts, even when it is being popped that cycle.
- Pointer wrap: read and write pointers are $clog2(FIFO_DEPTH)+1 bits. Full = MSBs differ and the low bits are equal. Empty = pointers equal.
- flush: at the edge, all buffers are emptied, cdb_valid <= 0 and rr_ptr <= 0. A same-cycle push is dropped. flush has priority over push and pop.
- en=0: no push, no pop, cdb_valid <= 0, all other state held. flush still acts when en=0.
- Order within one unit is FIFO. There is no ordering guarantee across units.

Decomposition:
- OoO_packages.pkg gains:
  - typedef cdb_entry_t {logic [TAG_W-1:0] tag; logic [BITWIDTH-1:0] data;} with the default parameters;
  - constant CDB_TAG_W;
  - helper functions tag_rs_id(tag) and tag_row(tag).
- Sub-module cdb_fifo (parameters T, DEPTH; ports clk, rst, flush, push, pop, din, dout, full, empty) is instantiated NRALUOP times via generate.
- Round-robin selection and the CDB output register live in the top module.

Test Plan:
- Reset: assert rst asynchronously mid-cycle while cdb_valid=1 -> cdb_valid drops immediately; after release res_ready=8'hFF, and the first grant scan starts at unit 0.
- Single result: unit 3 pushes tag 6'h1B, data 32'hDEADBEEF at edge E -> in the cycle after E+1, cdb_valid=1, cdb_tag=6'h1B, cdb_data=32'hDEADBEEF, cdb_src=3; next cycle cdb_valid=0.
- Contention: units 0, 5 and 7 push at the same edge with rr_ptr=0 -> three consecutive broadcasts with cdb_src 0, 5, 7 and no gaps.
- Fairness: units 1 and 2 push every cycle -> cdb_src alternates 1, 2, 1, 2. Neither unit's res_ready stays low for more than 2 cycles.
- Full/backpressure: all 8 units push every cycle (FIFO_DEPTH=2) -> res_ready[i] deasserts once its buffer is full. The scoreboard sees every accepted tag exactly once, and no tag that was offered with res_ready=0 is ever broadcast.
- Flush: 3 results buffered, then flush plus a push from unit 4 in the same cycle -> next cycle cdb_valid=0; no buffered or same-cycle tag is ever broadcast; res_ready all ones.
